mux_sel_sequencer: RTL and testbench
====================================

// Module: mux_sel_sequencer
// PURPOSE
//  Upstream driver/consumer for the mux4to1 operand select stage: holds four N-bit operand registers,
//  drives them onto the mux a/b/c/d inputs, then steps fn_sel 0..3 and captures each mux output
//  into a single-entry valid/ready result register. Lets the CPU datapath walk all four sources
//  with backpressure, without a combinational path from res_ready back to fn_sel's source.
// PARAMETERS
//  N        4   operand/result width; must match the attached mux4to1 N
// PORTS
//  clk       in   1  clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  wr_en     in   1  operand write strobe
//  wr_addr   in   2  operand select: 0=a 1=b 2=c 3=d
//  wr_data   in   N  operand write data
//  start     in   1  begin a 4-step sequence (sampled in IDLE only)
//  a,b,c,d   out  N  operand registers, wired to mux4to1 a..d
//  fn_sel    out  2  select driven to mux4to1
//  mux_out   in   N  mux4to1 out (combinational from a..d/fn_sel)
//  res_data  out  N  captured result
//  res_idx   out  2  fn_sel value that produced res_data
//  res_valid out  1  result register holds data
//  res_ready in   1  downstream accepts result
//  busy      out  1  high in RUN or DRAIN
//  done      out  1  one-cycle pulse after the 4th result is accepted
//  err       out  1  sticky checker flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: a..d=0, fn_sel=0, res_data=0, res_idx=0, res_valid=0, busy=0, done=0, err=0, state=IDLE.
//    Reset mid-sequence abandons it; any pending result is dropped.
//  - Writes: on clk with wr_en && !busy, reg[wr_addr] <= wr_data. wr_en while busy is ignored, so
//    operands stay stable for a whole sequence.
//  - FSM IDLE -> RUN on start (idx=0, fn_sel=0). start while busy is ignored.
//  - In the same IDLE cycle, wr_en and start both take effect. The new operand is used, because
//    the first capture is one cycle later.
//  - RUN: fn_sel=idx. Capture condition is (!res_valid || res_ready).
//    When it holds: res_data<=mux_out, res_idx<=idx, res_valid<=1, idx<=idx+1.
//    When it does not hold: hold idx/fn_sel, no capture, no loss.
//  - RUN, capture at idx==3 -> DRAIN. idx does not wrap into a 5th capture.
//  - DRAIN: fn_sel holds 3. On res_valid && res_ready: res_valid<=0, done<=1 for one cycle, -> IDLE.
//  - Outside DRAIN, res_valid clears on res_ready only if no new capture happens in the same cycle.
//    A capture and an accept in the same cycle keep res_valid=1 with the new data.
//  - Latency and throughput: start sampled at edge T0.
//    With res_ready=1: results valid T1..T4 (idx 0..3), done high T5, busy high T1..T4,
//    back-to-back sequence start accepted from T5.
//  - res_data/res_idx never change while res_valid && !res_ready.
//  - Widths: no arithmetic on data. idx is 2 bits; results are exact N-bit copies of mux_out.
// CONFIGURATION
//  MUX_SEQ_CHECK_EN defined:
//    - On every capture, compare mux_out with the internal operand selected by idx.
//    - On a mismatch, set err=1 (sticky until reset) and fire an $error in simulation.
//  MUX_SEQ_CHECK_EN undefined: comparator and flop absent; err tied to 0.
// TESTING
//  1. Write a=1,b=2,c=3,d=4; start; res_ready=1 -> res_data 1,2,3,4 with res_idx 0..3 on
//     consecutive cycles; done pulses once; busy falls.
//  2. Same operands, res_ready=0 for 3 cycles after the first valid -> res_data holds 1 and fn_sel
//     holds 1. Then 2,3,4 follow, with no drop and no duplicate.
//  3. During busy, wr_en addr=2 data=F -> ignored, results still 1,2,3,4. After done, c reads F.
//  4. start pulsed again mid-RUN -> ignored, exactly 4 results and one done.
//  5. rst_n low after the 2nd result -> all outputs 0 immediately. A new start after release
//     yields 0,0,0,0.
//  6. With MUX_SEQ_CHECK_EN, force mux_out=7 when idx=2 -> err=1 and stays 1.
//     Without the macro, err stays 0.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// Operand registers feeding a 4:1 mux; steps fn_sel 0..3 and captures each mux result into a
// single-entry valid/ready register. Optional capture checker under `MUX_SEQ_CHECK_EN.
module mux_sel_sequencer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [1:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic         start,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [N-1:0] c,
    output logic [N-1:0] d,
    output logic [1:0]   fn_sel,
    input  logic [N-1:0] mux_out,
    output logic [N-1:0] res_data,
    output logic [1:0]   res_idx,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic       cap;
    logic       done_nxt;

    assign busy   = (state != S_IDLE);
    assign fn_sel = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= 2'd0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cap       = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    idx_nxt   = 2'd0;
                end
            end
            S_RUN: begin
                cap = !res_valid || res_ready;
                if (cap) begin
                    // Last capture parks idx at 3 so fn_sel holds through DRAIN.
                    if (idx == 2'd3) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (res_valid && res_ready) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = 2'd0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = 2'd0;
            end
        endcase
    end

    // A capture wins over an accept, so a simultaneous pop/push keeps valid high with new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= 2'd0;
        end else if (cap) begin
            res_valid <= 1'b1;
            res_data  <= mux_out;
            res_idx   <= idx;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= '0;
            c <= '0;
            d <= '0;
        end else if (wr_en && !busy) begin
            case (wr_addr)
                2'd0:    a <= wr_data;
                2'd1:    b <= wr_data;
                2'd2:    c <= wr_data;
                default: d <= wr_data;
            endcase
        end
    end

`ifdef MUX_SEQ_CHECK_EN
    logic [N-1:0] sel_op;

    always_comb begin
        case (idx)
            2'd0:    sel_op = a;
            2'd1:    sel_op = b;
            2'd2:    sel_op = c;
            default: sel_op = d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (cap && (mux_out != sel_op)) begin
            err <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && cap) begin
            assert (mux_out == sel_op)
            else $error("mux_sel_sequencer: mux_out %h != operand %h at idx %0d", mux_out, sel_op, idx);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scenario bench for mux_sel_sequencer with a behavioural mux4to1 and a result scoreboard.
module tb_mux_sel_sequencer;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [1:0]   wr_addr;
    logic [N-1:0] wr_data;
    logic         start;
    logic [N-1:0] a, b, c, d;
    logic [1:0]   fn_sel;
    logic [N-1:0] mux_out;
    logic [N-1:0] res_data;
    logic [1:0]   res_idx;
    logic         res_valid;
    logic         res_ready;
    logic         busy;
    logic         done;
    logic         err;

    logic         force7;
    int           total = 0;
    int           bad = 0;
    int           done_cnt = 0;
    logic [N+1:0] exp_q[$];

    mux_sel_sequencer #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .a(a), .b(b), .c(c), .d(d), .fn_sel(fn_sel), .mux_out(mux_out),
        .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (fn_sel)
            2'd0:    mux_out = a;
            2'd1:    mux_out = b;
            2'd2:    mux_out = c;
            default: mux_out = d;
        endcase
        if (force7 && fn_sel == 2'd2) mux_out = 4'h7;
    end

    // Scoreboard: every accepted result must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid && res_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL accept_unexpected: got idx=%0d data=%h, expected no result", res_idx, res_data);
                end else begin
                    logic [N+1:0] e;
                    e = exp_q.pop_front();
                    if ({res_idx, res_data} !== e) begin
                        bad++;
                        $display("FAIL result: got idx=%0d data=%h, expected idx=%0d data=%h",
                                 res_idx, res_data, e[N+1:N], e[N-1:0]);
                    end
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [N-1:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_ops(input logic [N-1:0] va, vb, vc, vd);
        do_write(2'd0, va); do_write(2'd1, vb); do_write(2'd2, vc); do_write(2'd3, vd);
    endtask

    task automatic pulse_start(input logic [N-1:0] e0, e1, e2, e3);
        exp_q.push_back({2'd0, e0}); exp_q.push_back({2'd1, e1});
        exp_q.push_back({2'd2, e2}); exp_q.push_back({2'd3, e3});
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        int k;
        k = 0;
        while (done_cnt == base && k < 50) begin
            tick();
            k++;
        end
        total++;
        if (done_cnt == base) begin
            bad++;
            $display("FAIL %s_timeout: done count %0d, expected %0d", name, done_cnt, base + 1);
        end
        repeat (3) tick();
        total++;
        if (done_cnt != base + 1 || exp_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_end: done_cnt=%0d pending=%0d busy=%b, expected %0d 0 0",
                     name, done_cnt, exp_q.size(), busy, base + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = '0; start = 1'b0;
        res_ready = 1'b0; force7 = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({a, b, c, d, fn_sel, res_data, res_idx, res_valid, busy, done, err} !== '0) begin
            bad++;
            $display("FAIL reset_state: got a=%h b=%h c=%h d=%h sel=%0d rd=%h ri=%0d rv=%b busy=%b done=%b err=%b, expected all 0",
                     a, b, c, d, fn_sel, res_data, res_idx, res_valid, busy, done, err);
        end
    endtask

    task automatic test_basic();
        int base;
        load_ops(4'h1, 4'h2, 4'h3, 4'h4);
        total++;
        if ({a, b, c, d} !== 16'h1234) begin
            bad++;
            $display("FAIL operands: got %h%h%h%h, expected 1234", a, b, c, d);
        end
        res_ready = 1'b1;
        base = done_cnt;
        pulse_start(4'h1, 4'h2, 4'h3, 4'h4);
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++;
            if (k <= 4 && (busy !== 1'b1 || res_valid !== 1'b1 || res_idx !== 2'(k - 1) || done !== 1'b0)) begin
                bad++;
                $display("FAIL basic_cycle%0d: busy=%b valid=%b idx=%0d done=%b, expected 1 1 %0d 0",
                         k, busy, res_valid, res_idx, done, k - 1);
            end else if (k == 5 && (busy !== 1'b0 || done !== 1'b1 || res_valid !== 1'b0)) begin
                bad++;
                $display("FAIL basic_done: busy=%b done=%b valid=%b, expected 0 1 0", busy, done, res_valid);
            end
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done=%b one cycle later, expected 0", done);
        end
        wait_done(base, "basic");
    endtask

    task automatic test_backpressure();
        int base;
        res_ready = 1'b0;
        base = done_cnt;
        pulse_start(4'h1, 4'h2, 4'h3, 4'h4);
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (res_valid !== 1'b1 || res_data !== 4'h1 || res_idx !== 2'd0 || fn_sel !== 2'd1) begin
                bad++;
                $display("FAIL hold%0d: valid=%b data=%h idx=%0d sel=%0d, expected 1 1 0 1",
                         k, res_valid, res_data, res_idx, fn_sel);
            end
        end
        res_ready = 1'b1;
        wait_done(base, "backpressure");
    endtask

    task automatic test_write_busy();
        int base;
        base = done_cnt;
        pulse_start(4'h1, 4'h2, 4'h3, 4'h4);
        do_write(2'd2, 4'hF);
        total++;
        if (c !== 4'h3) begin
            bad++;
            $display("FAIL write_busy: c=%h, expected 3", c);
        end
        wait_done(base, "write_busy");
        do_write(2'd2, 4'hF);
        total++;
        if (c !== 4'hF) begin
            bad++;
            $display("FAIL write_idle: c=%h, expected f", c);
        end
        do_write(2'd2, 4'h3);
    endtask

    task automatic test_start_midrun();
        int base;
        base = done_cnt;
        pulse_start(4'h1, 4'h2, 4'h3, 4'h4);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(base, "start_midrun");
    endtask

    task automatic test_reset_mid();
        int base;
        pulse_start(4'h1, 4'h2, 4'h3, 4'h4);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({a, b, c, d, fn_sel, res_data, res_idx, res_valid, busy, done, err} !== '0) begin
            bad++;
            $display("FAIL reset_mid: rv=%b rd=%h ri=%0d busy=%b a..d=%h%h%h%h sel=%0d, expected all 0",
                     res_valid, res_data, res_idx, busy, a, b, c, d, fn_sel);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        base = done_cnt;
        pulse_start(4'h0, 4'h0, 4'h0, 4'h0);
        wait_done(base, "after_reset");
    endtask

    task automatic test_checker();
        int base;
        logic exp_err;
`ifdef MUX_SEQ_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        load_ops(4'h1, 4'h2, 4'h3, 4'h4);
        force7 = 1'b1;
        base = done_cnt;
        pulse_start(4'h1, 4'h2, 4'h7, 4'h4);
        wait_done(base, "checker");
        force7 = 1'b0;
        total++;
        if (err !== exp_err) begin
            bad++;
            $display("FAIL err_set: err=%b, expected %b", err, exp_err);
        end
        base = done_cnt;
        pulse_start(4'h1, 4'h2, 4'h3, 4'h4);
        wait_done(base, "checker_clean");
        total++;
        if (err !== exp_err) begin
            bad++;
            $display("FAIL err_sticky: err=%b, expected %b", err, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_write_busy();
        test_start_midrun();
        test_reset_mid();
        test_checker();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
